// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with built-in sample-tick divider and saturating match counter.
// Optional sticky match flag b_hold is enabled by defining SEQ_DET_STICKY_EN.
module seq_detector_param #(
    parameter int unsigned        PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
    parameter int unsigned        DIV     = 4,
    parameter bit                 OVERLAP = 1'b1,
    parameter int unsigned        CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               seq,
    input  logic               pat_ld,
    input  logic [PAT_LEN-1:0] pat_in,
    output logic               tick,
    output logic               b,
    output logic [CNT_W-1:0]   match_cnt
`ifdef SEQ_DET_STICKY_EN
    ,
    output logic               b_hold
`endif
);

    localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic [DIV_W-1:0]   div_cnt, div_cnt_n;
    // Only the newest PAT_LEN-1 samples are stored; the window is completed by the current seq.
    logic [PAT_LEN-2:0] shreg, shreg_n;
    logic [PAT_LEN-1:0] shreg_s;
    logic [PAT_LEN-1:0] pat_reg, pat_n;
    logic [FILL_W-1:0]  fill, fill_n, fill_s;
    logic [CNT_W-1:0]   cnt_n;
    logic               tick_n, b_n, hit;
`ifdef SEQ_DET_STICKY_EN
    logic               hold_n;
`endif

    // Next-state logic for divider, sample window, match pulse and counter.
    always_comb begin
        div_cnt_n = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        tick_n    = (div_cnt == DIV_LAST);
        shreg_s   = {shreg, seq};
        fill_s    = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
        hit       = tick && !pat_ld && (fill_s == FILL_FULL) && (shreg_s == pat_reg);
        shreg_n   = shreg;
        fill_n    = fill;
        pat_n     = pat_reg;
        b_n       = 1'b0;
        cnt_n     = match_cnt;
`ifdef SEQ_DET_STICKY_EN
        hold_n    = b_hold | b;
`endif
        if (pat_ld) begin
            // A coincident tick is dropped; a b already on the output is left uncounted.
            pat_n   = pat_in;
            shreg_n = '0;
            fill_n  = '0;
            cnt_n   = '0;
`ifdef SEQ_DET_STICKY_EN
            hold_n  = 1'b0;
`endif
        end else begin
            if (tick) begin
                shreg_n = shreg_s[PAT_LEN-2:0];
                fill_n  = (hit && !OVERLAP) ? '0 : fill_s;
            end
            b_n = hit;
            if (b && (match_cnt != CNT_MAX)) begin
                cnt_n = match_cnt + CNT_W'(1);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt   <= '0;
            tick      <= 1'b0;
            shreg     <= '0;
            fill      <= '0;
            pat_reg   <= PATTERN;
            b         <= 1'b0;
            match_cnt <= '0;
`ifdef SEQ_DET_STICKY_EN
            b_hold    <= 1'b0;
`endif
        end else begin
            div_cnt   <= div_cnt_n;
            tick      <= tick_n;
            shreg     <= shreg_n;
            fill      <= fill_n;
            pat_reg   <= pat_n;
            b         <= b_n;
            match_cnt <= cnt_n;
`ifdef SEQ_DET_STICKY_EN
            b_hold    <= hold_n;
`endif
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: two DIV=4 instances (overlap on/off) share a bit stream,
// a third DIV=1, CNT_W=2 instance checks per-cycle sampling and counter saturation.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       seq_a = 1'b0;
    logic       ld_a = 1'b0;
    logic [3:0] pin_a = 4'h0;
    logic       seq_c = 1'b0;
    logic [3:0] pin_c = 4'h0;

    logic       tick0, b0, tick1, b1, tick2, b2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;
`ifdef SEQ_DET_STICKY_EN
    logic       hold0, hold1, hold2;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       s;
        logic       ld;
        logic [3:0] pin;
        int         eb0;
        int         eb1;
        bit         cc;
        int         ec0;
        int         ec1;
    } vec_t;
    vec_t v[14];

    always #5 clk = ~clk;

    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1101), .DIV(4), .OVERLAP(1'b1), .CNT_W(8)) u_ovl (
        .clk(clk), .rst(rst), .seq(seq_a), .pat_ld(ld_a), .pat_in(pin_a),
        .tick(tick0), .b(b0), .match_cnt(cnt0)
`ifdef SEQ_DET_STICKY_EN
        , .b_hold(hold0)
`endif
    );

    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1101), .DIV(4), .OVERLAP(1'b0), .CNT_W(8)) u_novl (
        .clk(clk), .rst(rst), .seq(seq_a), .pat_ld(ld_a), .pat_in(pin_a),
        .tick(tick1), .b(b1), .match_cnt(cnt1)
`ifdef SEQ_DET_STICKY_EN
        , .b_hold(hold1)
`endif
    );

    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1101), .DIV(1), .OVERLAP(1'b0), .CNT_W(2)) u_fast (
        .clk(clk), .rst(rst), .seq(seq_c), .pat_ld(1'b0), .pat_in(pin_c),
        .tick(tick2), .b(b2), .match_cnt(cnt2)
`ifdef SEQ_DET_STICKY_EN
        , .b_hold(hold2)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick();
        int n = 0;
        while (tick0 !== 1'b1 && n < 16) begin
            step();
            n++;
        end
        checks++;
        if (tick0 !== 1'b1) begin
            errors++;
            $display("FAIL wait_tick: no tick after %0d cycles, expected within 16", n);
        end
    endtask

    initial begin
        // s ld pin eb0 eb1 cc ec0 ec1 ; one record per sample tick
        v[0]  = '{1'b1, 1'b0, 4'h0, 0, 0, 1'b0, 0, 0};
        v[1]  = '{1'b1, 1'b0, 4'h0, 0, 0, 1'b0, 0, 0};
        v[2]  = '{1'b0, 1'b0, 4'h0, 0, 0, 1'b0, 0, 0};
        v[3]  = '{1'b1, 1'b0, 4'h0, 1, 1, 1'b0, 0, 0};
        v[4]  = '{1'b1, 1'b0, 4'h0, 0, 0, 1'b0, 0, 0};
        v[5]  = '{1'b0, 1'b0, 4'h0, 0, 0, 1'b0, 0, 0};
        v[6]  = '{1'b1, 1'b0, 4'h0, 1, 0, 1'b1, 2, 1};
        v[7]  = '{1'b1, 1'b0, 4'h0, 0, 0, 1'b0, 0, 0};
        v[8]  = '{1'b1, 1'b0, 4'h0, 0, 0, 1'b0, 0, 0};
        v[9]  = '{1'b1, 1'b1, 4'b0110, 0, 0, 1'b1, 0, 0};
        v[10] = '{1'b0, 1'b0, 4'h0, 0, 0, 1'b0, 0, 0};
        v[11] = '{1'b1, 1'b0, 4'h0, 0, 0, 1'b0, 0, 0};
        v[12] = '{1'b1, 1'b0, 4'h0, 0, 0, 1'b0, 0, 0};
        v[13] = '{1'b0, 1'b0, 4'h0, 1, 1, 1'b1, 1, 1};

        // Held in reset
        repeat (3) step();
        chk("rst tick0", 32'(tick0), 0);
        chk("rst b0", 32'(b0), 0);
        chk("rst cnt0", 32'(cnt0), 0);
        chk("rst tick2", 32'(tick2), 0);
        rst = 1'b0;

        // Divider: ticks on cycles 4,8,...,20 for DIV=4, every cycle for DIV=1
        for (int c = 1; c <= 20; c++) begin
            step();
            chk($sformatf("tick0 c%0d", c), 32'(tick0), (c % 4 == 0) ? 1 : 0);
            chk($sformatf("tick2 c%0d", c), 32'(tick2), 1);
            chk($sformatf("b0 c%0d", c), 32'(b0), 0);
            chk($sformatf("cnt0 c%0d", c), 32'(cnt0), 0);
        end

        // Overlap vs restart, then pattern reload coincident with a tick
        for (int i = 0; i < 14; i++) begin
            wait_tick();
            seq_a = v[i].s;
            ld_a  = v[i].ld;
            pin_a = v[i].pin;
            step();
            ld_a = 1'b0;
            chk($sformatf("b0 v%0d", i), 32'(b0), v[i].eb0);
            chk($sformatf("b1 v%0d", i), 32'(b1), v[i].eb1);
            step();
            chk($sformatf("b0 low v%0d", i), 32'(b0), 0);
            chk($sformatf("b1 low v%0d", i), 32'(b1), 0);
            if (v[i].cc) begin
                chk($sformatf("cnt0 v%0d", i), 32'(cnt0), v[i].ec0);
                chk($sformatf("cnt1 v%0d", i), 32'(cnt1), v[i].ec1);
            end
        end
        seq_a = 1'b0;

        // DIV=1: 1101 five times back to back, counter saturates at 3
        begin
            logic [3:0] p5;
            p5 = 4'b1101;
            for (int i = 0; i < 20; i++) begin
                seq_c = p5[3 - (i % 4)];
                step();
                chk($sformatf("b2 bit%0d", i), 32'(b2), (i % 4 == 3) ? 1 : 0);
            end
        end
        seq_c = 1'b0;
        step();
        step();
        chk("cnt2 saturated", 32'(cnt2), 3);

        // Async reset mid-window: three bits of 0110, reset, then one more bit
        chk("cnt0 pre-rst", 32'(cnt0), 1);
`ifdef SEQ_DET_STICKY_EN
        chk("hold0 pre-rst", 32'(hold0), 1);
        chk("hold1 pre-rst", 32'(hold1), 1);
`endif
        for (int i = 0; i < 3; i++) begin
            wait_tick();
            seq_a = (i == 0) ? 1'b0 : 1'b1;
            step();
            chk($sformatf("b0 pre-rst%0d", i), 32'(b0), 0);
        end
        #2 rst = 1'b1;
        #1;
        chk("async tick0", 32'(tick0), 0);
        chk("async b0", 32'(b0), 0);
        chk("async cnt0", 32'(cnt0), 0);
        chk("async cnt1", 32'(cnt1), 0);
        chk("async cnt2", 32'(cnt2), 0);
`ifdef SEQ_DET_STICKY_EN
        chk("async hold0", 32'(hold0), 0);
        chk("async hold1", 32'(hold1), 0);
        chk("async hold2", 32'(hold2), 0);
`endif
        step();
        rst = 1'b0;
        wait_tick();
        seq_a = 1'b1;
        step();
        chk("post-rst b0", 32'(b0), 0);
        chk("post-rst b1", 32'(b1), 0);
        step();
        chk("post-rst cnt0", 32'(cnt0), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
